// File: rtl/uart_boot_sequencer_pkg.sv
// Shared definitions for the UART boot sequencer: FSM state encoding,
// default frame sync byte, word-assembly constants and a state helper.
package uart_boot_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_RUN  = 3'd5,
    ST_ERR  = 3'd6
  } boot_state_e;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // Index of the final byte lane of a little-endian 32-bit word.
  localparam logic [1:0] LANE_LAST = 2'd3;

  // States in which a frame is being received (busy, timer armed).
  function automatic logic is_busy(input boot_state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_boot_sequencer_packer.sv
// boot_word_packer: assembles little-endian 32-bit words from a byte stream
// and keeps the running XOR checksum of every byte accepted.
//   clk, reset   : clock / asynchronous active-high reset
//   clear_i      : synchronous clear of lane counter, shift register, checksum
//   byte_vld_i   : accept byte_i this cycle
//   byte_i       : payload byte
//   word_done_o  : combinational, high when the accepted byte completes a word
//   word_o       : the completed word (valid with word_done_o)
//   acc_o        : XOR of all bytes accepted since the last clear
module boot_word_packer
  import uart_boot_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_o,
  output logic [7:0]  acc_o
);

  logic [1:0]  lane_q;
  logic [23:0] shreg_q;
  logic [7:0]  acc_q;

  // Bytes enter at the top and shift down, so after three bytes the first one
  // sits in bits 7:0 and the fourth byte completes the word directly.
  assign word_done_o = byte_vld_i && (lane_q == LANE_LAST);
  assign word_o      = {byte_i, shreg_q};
  assign acc_o       = acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q  <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
    end else if (clear_i) begin
      lane_q  <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
    end else if (byte_vld_i) begin
      lane_q  <= lane_q + 2'd1;
      shreg_q <= {byte_i, shreg_q[23:8]};
      acc_q   <= acc_q ^ byte_i;
    end
  end

endmodule

// File: rtl/uart_boot_sequencer.sv
// uart_boot_sequencer: holds the core in reset, receives a framed program
// image over UART (MAGIC, LEN lo, LEN hi, N x 4 data bytes, XOR checksum),
// writes the words into IMEM and releases the core on a good checksum.
//   clk, reset    : clock / asynchronous active-high reset
//   rx_valid      : one-cycle strobe per received byte; rx_data the byte
//   imem_we       : one-cycle IMEM write strobe; imem_addr / imem_wdata
//   cpu_reset     : 1 holds the core in reset
//   busy          : frame in progress
//   error         : last frame failed; cleared by the next sync byte
//   words_loaded  : words written in the current/last frame
module uart_boot_sequencer
  import uart_boot_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  MAGIC       = DEFAULT_MAGIC,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned TMR_W       = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  boot_state_e       state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic [15:0]       len_full;
  logic              sync_hit;
  logic              pk_vld;
  logic              word_done;
  logic [31:0]       word;
  logic [7:0]        acc;

  assign len_full = {rx_data, len_lo_q};

  // MAGIC only resynchronises outside a frame; inside a frame it is payload.
  assign sync_hit = rx_valid && (rx_data == MAGIC) &&
                    ((state_q == ST_SYNC) || (state_q == ST_RUN) || (state_q == ST_ERR));

  assign pk_vld = rx_valid && (state_q == ST_DATA);

  boot_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (sync_hit),
    .byte_vld_i  (pk_vld),
    .byte_i      (rx_data),
    .word_done_o (word_done),
    .word_o      (word),
    .acc_o       (acc)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;

    case (state_q)
      ST_SYNC, ST_RUN, ST_ERR: begin
        if (sync_hit) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_valid) begin
          len_d = len_full;
          if (len_full == 16'd0)                state_d = ST_CSUM;
          else if ({1'b0, len_full} > MAX_WORDS) state_d = ST_ERR;
          else                                  state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // words_q lags the 4th byte by two cycles, which is always settled
        // before the next word can complete (at least four bytes later).
        if (word_done && (({1'b0, words_q} + 17'd1) == {1'b0, len_q})) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (rx_valid) state_d = (rx_data == acc) ? ST_RUN : ST_ERR;
      end
      default: state_d = ST_SYNC;
    endcase

    // Inter-byte timeout; a byte arriving on the expiry cycle takes priority.
    if (is_busy(state_q)) begin
      if (rx_valid) begin
        timer_d = '0;
      end else if (timer_q == TMR_LAST) begin
        state_d = ST_ERR;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end else begin
      timer_d = '0;
    end

    we_d    = word_done;
    wdata_d = word_done ? word : wdata_q;

    // Address and count advance the cycle after the write strobe.
    addr_d  = addr_q;
    words_d = words_q;
    if (sync_hit) begin
      addr_d  = '0;
      words_d = '0;
    end else if (we_q) begin
      addr_d  = addr_q + ADDR_W'(1);
      words_d = words_q + 16'd1;
    end

    // Release only once RUN has been entered; leaving RUN re-asserts at once.
    cpu_rst_d = !((state_q == ST_RUN) && (state_d == ST_RUN));
    busy_d    = is_busy(state_d);

    error_d = error_q;
    if (sync_hit)                error_d = 1'b0;
    else if (state_d == ST_ERR)  error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SYNC;
      timer_q   <= '0;
      len_lo_q  <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      words_q   <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_reset    = cpu_rst_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_boot_sequencer.sv
`timescale 1ns/1ps
module tb_uart_boot_sequencer;

  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned TIMEOUT_CYC = 40;
  localparam int unsigned TMR_W       = 8;
  localparam logic [7:0]  MAGIC       = 8'hA5;
  localparam int          MAXW        = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              error;
  logic [15:0]       words_loaded;

  always #5 clk = ~clk;

  uart_boot_sequencer #(
    .ADDR_W      (ADDR_W),
    .MAGIC       (MAGIC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  int         checks   = 0;
  int         failures = 0;
  bit         exp_run;
  bit         exp_inc;
  int         exp_words;
  bit         exp_cpu_rst = 1'b1;
  bit         exp_err     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: every IMEM write must match the oldest expected one.
  logic prev_we = 1'b0;
  always @(negedge clk) begin : monitor
    wr_t e;
    if (imem_we) begin
      if (prev_we) check("we_back_to_back", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.a));
        check("wr_data", imem_wdata, e.d);
      end
    end
    prev_we <= imem_we;
  end

  // Frame-level reference: parse the byte list by the framing rules and
  // derive writes, final outcome and word count.
  task automatic model_frame();
    int n, avail, full, sz;
    logic [7:0] cs;
    wr_t w;
    sz = frame_q.size();
    n  = int'({frame_q[2], frame_q[1]});
    exp_run = 1'b0; exp_inc = 1'b0; exp_words = 0;
    if (n > MAXW) return;
    avail = (sz - 3) / 4;
    full  = (n < avail) ? n : avail;
    for (int i = 0; i < full; i++) begin
      w.a = ADDR_W'(i % MAXW);
      w.d = {frame_q[3+4*i+3], frame_q[3+4*i+2], frame_q[3+4*i+1], frame_q[3+4*i]};
      exp_q.push_back(w);
    end
    exp_words = full;
    cs = 8'h00;
    for (int i = 3; i < sz && i < 3 + 4 * n; i++) cs ^= frame_q[i];
    if (sz < 3 + 4 * n + 1) exp_inc = 1'b1;
    else                    exp_run = (frame_q[3 + 4 * n] == cs);
  endtask

  task automatic finish_frame(input bit bad);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 3; i < frame_q.size(); i++) cs ^= frame_q[i];
    frame_q.push_back(bad ? (cs ^ 8'h5A) : cs);
  endtask

  task automatic build_random(input int n);
    frame_q.delete();
    frame_q.push_back(MAGIC);
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++)
      frame_q.push_back(($urandom_range(0, 3) == 0) ? MAGIC : 8'($urandom));
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_frame(input int stall_idx);
    int gap;
    model_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == frame_q.size() - 1) gap = 0;
      else if (i == stall_idx)     gap = TIMEOUT_CYC - 1;
      else                         gap = $urandom_range(0, 3);
      send_byte(frame_q[i], gap);
      if (stall_idx >= 0 && i == stall_idx + 1) check("byte_wins_timeout_busy", 32'(busy), 32'd1);
    end
    if (exp_inc) begin
      repeat (TIMEOUT_CYC - 1) @(negedge clk);
      check("pre_timeout_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end else begin
      if (exp_run) check("release_latency_cpu_reset", 32'(cpu_reset), 32'd1);
      @(negedge clk);
    end
    check("busy_end", 32'(busy), 32'd0);
    check("error_end", 32'(error), 32'(!exp_run));
    check("cpu_reset_end", 32'(cpu_reset), 32'(!exp_run));
    check("words_loaded", 32'(words_loaded), 32'(exp_words));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    if (exp_run) check("imem_addr_end", 32'(imem_addr), 32'(exp_words % MAXW));
    exp_cpu_rst = !exp_run;
    exp_err     = !exp_run;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_we"},    32'(imem_we), 32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_reset"},  32'(cpu_reset), 32'd1);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_error"},      32'(error), 32'd0);
    check({tag, "_words"},      32'(words_loaded), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    wr_t w;
    logic [7:0] junk;
    int n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Two-word program with correct checksum.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    finish_frame(1'b0);
    run_frame(-1);

    // Same frame with a wrong checksum, then a clean resend.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    finish_frame(1'b1);
    run_frame(-1);
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    finish_frame(1'b0);
    run_frame(-1);

    // Truncated frame: silence after a partial word times out.
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    run_frame(-1);

    // Byte arriving exactly on the expiry cycle keeps the frame alive.
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    finish_frame(1'b0);
    run_frame(2);

    // Length one beyond capacity, then a zero-length frame.
    frame_q = '{8'hA5, 8'(MAXW + 1), 8'h00};
    run_frame(-1);
    frame_q = '{8'hA5, 8'h00, 8'h00};
    finish_frame(1'b0);
    run_frame(-1);

    // Full-capacity image: address wraps to zero after the last write.
    build_random(MAXW);
    finish_frame(1'b0);
    run_frame(-1);

    // Sync bytes inside the payload are data.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h01};
    finish_frame(1'b0);
    run_frame(-1);

    // From RUN, a sync byte re-asserts core reset on the same edge; then
    // an asynchronous reset in the middle of DATA.
    send_byte(MAGIC, 0);
    check("resync_cpu_reset", 32'(cpu_reset), 32'd1);
    check("resync_busy", 32'(busy), 32'd1);
    w.a = '0;
    w.d = 32'hDDCCBBAA;
    exp_q.push_back(w);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 1);
    send_byte(8'hDD, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    check("mid_frame_words", 32'(words_loaded), 32'd1);
    check("mid_frame_pending", 32'(exp_q.size()), 32'd0);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_cpu_rst = 1'b1;
    exp_err     = 1'b0;

    // Randomised frames, with stray bytes between them and occasional
    // bad checksums or truncation.
    for (int f = 0; f < 12; f++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++) begin
        junk = 8'($urandom);
        if (junk == MAGIC) junk = 8'h3C;
        send_byte(junk, $urandom_range(0, 2));
        check("idle_cpu_reset", 32'(cpu_reset), 32'(exp_cpu_rst));
        check("idle_error", 32'(error), 32'(exp_err));
      end
      n = $urandom_range(0, MAXW);
      build_random(n);
      finish_frame($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        for (int k = $urandom_range(1, 3); k > 0 && frame_q.size() > 3; k--) void'(frame_q.pop_back());
      end
      run_frame(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
